// File: rtl/imem_sync_if.sv
// Bus bundle for imem_sync: instruction fetch channel plus the program-load stream.
// The master side is the core/loader; the slave side is the memory.
interface imem_sync_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 512
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic            fetch_req;
    logic [XLEN-1:0] fetch_addr;
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_instr;
    logic [1:0]      fetch_fault;
    logic            busy;

    logic            prog_start;
    logic [XLEN-1:0] prog_addr;
    logic [LW-1:0]   prog_len;
    logic            prog_wvalid;
    logic [XLEN-1:0] prog_wdata;
    logic            prog_wready;
    logic            prog_done;
    logic            prog_err;

    modport master (
        output fetch_req, fetch_addr,
        output prog_start, prog_addr, prog_len, prog_wvalid, prog_wdata,
        input  fetch_valid, fetch_instr, fetch_fault, busy,
        input  prog_wready, prog_done, prog_err
    );

    modport slave (
        input  fetch_req, fetch_addr,
        input  prog_start, prog_addr, prog_len, prog_wvalid, prog_wdata,
        output fetch_valid, fetch_instr, fetch_fault, busy,
        output prog_wready, prog_done, prog_err
    );
endinterface

// File: rtl/imem_sync.sv
// Synchronous instruction memory: registered one-cycle fetch with alignment/range faults,
// and a run-time program-load stream that writes consecutive words from a start address.
module imem_sync #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     DEPTH        = 512,
    parameter logic [XLEN-1:0] BASE_ADDRESS = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013
) (
    input logic         clk,
    input logic         rst_n,
    imem_sync_if.slave  bus
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned LW = IW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Word index relative to the memory base; unsigned XLEN-bit subtraction.
    function automatic logic [XLEN-1:0] word_index(input logic [XLEN-1:0] addr);
        return (addr - BASE_ADDRESS) >> 2;
    endfunction

    function automatic logic out_of_range(input logic [XLEN-1:0] addr,
                                          input logic [XLEN-1:0] widx);
        return (addr < BASE_ADDRESS) || (widx >= XLEN'(DEPTH));
    endfunction

    logic [XLEN-1:0] mem_q [DEPTH];

    state_e          state_q;
    logic [IW-1:0]   ptr_q;
    logic [LW-1:0]   cnt_q;
    logic            busy_q;
    logic            wready_q;
    logic            done_q;
    logic            err_q;
    logic            fvalid_q;
    logic [XLEN-1:0] finstr_q;
    logic [1:0]      ffault_q;

    logic [XLEN-1:0] f_widx_s;
    logic            f_mis_s;
    logic            f_oor_s;
    logic [XLEN-1:0] p_widx_s;
    logic            p_mis_s;
    logic            p_oor_s;
    logic [LW:0]     p_end_s;
    logic            p_ok_s;
    logic            we_s;

    // Address decode for the fetch and load ports; end index is one bit wider so it cannot wrap.
    always_comb begin
        f_widx_s = word_index(bus.fetch_addr);
        f_mis_s  = (bus.fetch_addr[1:0] != 2'b00);
        f_oor_s  = out_of_range(bus.fetch_addr, f_widx_s);
        p_widx_s = word_index(bus.prog_addr);
        p_mis_s  = (bus.prog_addr[1:0] != 2'b00);
        p_oor_s  = out_of_range(bus.prog_addr, p_widx_s);
        p_end_s  = {2'b00, p_widx_s[IW-1:0]} + {1'b0, bus.prog_len};
        p_ok_s   = (bus.prog_len != {LW{1'b0}}) && !p_mis_s && !p_oor_s
                   && (p_end_s <= (LW+1)'(DEPTH));
        we_s     = rst_n && (state_q == ST_LOAD) && bus.prog_wvalid && wready_q;
    end

    // RAM write port; kept free of reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[ptr_q] <= bus.prog_wdata;
        end
    end

    // Load FSM plus the registered fetch path (RAM read port).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= {IW{1'b0}};
            cnt_q    <= {LW{1'b0}};
            busy_q   <= 1'b0;
            wready_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            fvalid_q <= 1'b0;
            finstr_q <= NOP_INSTR;
            ffault_q <= 2'b00;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            fvalid_q <= 1'b0;
            ffault_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (bus.fetch_req) begin
                        fvalid_q <= 1'b1;
                        ffault_q <= {f_oor_s, f_mis_s};
                        if (f_oor_s || f_mis_s) begin
                            finstr_q <= NOP_INSTR;
                        end else begin
                            finstr_q <= mem_q[f_widx_s[IW-1:0]];
                        end
                    end else begin
                        finstr_q <= finstr_q;
                    end
                    if (bus.prog_start && p_ok_s) begin
                        state_q  <= ST_LOAD;
                        ptr_q    <= p_widx_s[IW-1:0];
                        cnt_q    <= bus.prog_len;
                        busy_q   <= 1'b1;
                        wready_q <= 1'b1;
                    end else if (bus.prog_start) begin
                        err_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Fetches are dropped here: valid and fault stay at their cleared defaults.
                    if (bus.prog_wvalid && wready_q) begin
                        ptr_q <= ptr_q + {{(IW-1){1'b0}}, 1'b1};
                        cnt_q <= cnt_q - {{(LW-1){1'b0}}, 1'b1};
                        if (cnt_q == {{(LW-1){1'b0}}, 1'b1}) begin
                            state_q  <= ST_DONE;
                            wready_q <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end else begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    wready_q <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    wready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fetch_valid = fvalid_q;
    assign bus.fetch_instr = finstr_q;
    assign bus.fetch_fault = ffault_q;
    assign bus.busy        = busy_q;
    assign bus.prog_wready = wready_q;
    assign bus.prog_done   = done_q;
    assign bus.prog_err    = err_q;

endmodule

// File: tb/tb_imem_sync.sv
// Directed bench for imem_sync: program loads, fetches, faults, rejected loads and reset mid-load.
module tb_imem_sync;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 512;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    imem_sync_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    imem_sync #(
        .XLEN(XLEN), .DEPTH(DEPTH),
        .BASE_ADDRESS(32'h0000_0000), .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_chk(input string tag, input logic [31:0] addr,
                             input logic [31:0] instr, input logic [1:0] fault);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        tick();
        bus.fetch_req  = 1'b0;
        check_eq({tag, "_valid"}, bus.fetch_valid, 32'h1);
        check_eq({tag, "_instr"}, bus.fetch_instr, instr);
        check_eq({tag, "_fault"}, bus.fetch_fault, fault);
    endtask

    task automatic start_load(input logic [31:0] addr, input logic [9:0] len);
        bus.prog_start = 1'b1;
        bus.prog_addr  = addr;
        bus.prog_len   = len;
        tick();
        bus.prog_start = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] data);
        bus.prog_wvalid = 1'b1;
        bus.prog_wdata  = data;
        tick();
        bus.prog_wvalid = 1'b0;
    endtask

    logic [31:0] w1 [3];
    logic [31:0] w4 [4];
    logic [31:0] n5 [4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        w1[0] = 32'h0050_0093; w1[1] = 32'h00A0_0113; w1[2] = 32'h0020_81B3;
        w4[0] = 32'h1111_1111; w4[1] = 32'h2222_2222; w4[2] = 32'h3333_3333; w4[3] = 32'h4444_4444;
        n5[0] = 32'hAAAA_0001; n5[1] = 32'hAAAA_0002; n5[2] = 32'hAAAA_0003; n5[3] = 32'hAAAA_0004;

        rst_n = 1'b0;
        bus.fetch_req = 1'b0;   bus.fetch_addr = 32'h0;
        bus.prog_start = 1'b0;  bus.prog_addr = 32'h0;  bus.prog_len = 10'd0;
        bus.prog_wvalid = 1'b0; bus.prog_wdata = 32'h0;
        tick();
        tick();
        check_eq("rst_valid",  bus.fetch_valid, 32'h0);
        check_eq("rst_instr",  bus.fetch_instr, 32'h0000_0013);
        check_eq("rst_fault",  bus.fetch_fault, 32'h0);
        check_eq("rst_busy",   bus.busy,        32'h0);
        check_eq("rst_wready", bus.prog_wready, 32'h0);
        check_eq("rst_done",   bus.prog_done,   32'h0);
        check_eq("rst_err",    bus.prog_err,    32'h0);
        rst_n = 1'b1;
        tick();

        // 1: load three words at 0x0, then fetch them back-to-back
        start_load(32'h0, 10'd3);
        check_eq("t1_busy", bus.busy, 32'h1);
        for (int i = 0; i < 3; i++) begin
            check_eq("t1_wready", bus.prog_wready, 32'h1);
            check_eq("t1_nodone", bus.prog_done, 32'h0);
            write_word(w1[i]);
        end
        check_eq("t1_done",      bus.prog_done,   32'h1);
        check_eq("t1_done_busy", bus.busy,        32'h1);
        check_eq("t1_done_wrdy", bus.prog_wready, 32'h0);
        tick();
        check_eq("t1_done_off", bus.prog_done, 32'h0);
        check_eq("t1_busy_off", bus.busy,      32'h0);
        bus.fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.fetch_addr = 32'(i * 4);
            tick();
            check_eq("t1_f_valid", bus.fetch_valid, 32'h1);
            check_eq("t1_f_instr", bus.fetch_instr, w1[i]);
            check_eq("t1_f_fault", bus.fetch_fault, 32'h0);
        end
        bus.fetch_req = 1'b0;
        tick();
        check_eq("t1_idle_valid", bus.fetch_valid, 32'h0);
        check_eq("t1_idle_hold",  bus.fetch_instr, w1[2]);

        // 2: fault cases
        fetch_chk("t2_mis",  32'h0000_0006, 32'h0000_0013, 2'b01);
        fetch_chk("t2_oor",  32'h0000_0800, 32'h0000_0013, 2'b10);
        fetch_chk("t2_both", 32'h0000_0802, 32'h0000_0013, 2'b11);

        // 3: rejected loads
        start_load(32'h0000_07F8, 10'd3);
        check_eq("t3_ovf_err",  bus.prog_err, 32'h1);
        check_eq("t3_ovf_busy", bus.busy,     32'h0);
        tick();
        check_eq("t3_err_pulse", bus.prog_err, 32'h0);
        start_load(32'h0, 10'd0);
        check_eq("t3_len0_err", bus.prog_err, 32'h1);
        start_load(32'h0000_0002, 10'd1);
        check_eq("t3_mis_err",  bus.prog_err, 32'h1);
        check_eq("t3_mis_busy", bus.busy,     32'h0);

        // 4: load ending exactly at the last word, with a gap and a dropped fetch
        start_load(32'h0000_07F0, 10'd4);
        check_eq("t4_err",  bus.prog_err, 32'h0);
        check_eq("t4_busy", bus.busy,     32'h1);
        write_word(w4[0]);
        write_word(w4[1]);
        bus.prog_wdata = 32'hDEAD_BEEF;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h0000_0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.fetch_req = 1'b0;
            check_eq("t4_drop_valid", bus.fetch_valid, 32'h0);
            check_eq("t4_drop_fault", bus.fetch_fault, 32'h0);
            check_eq("t4_gap_wready", bus.prog_wready, 32'h1);
            check_eq("t4_gap_done",   bus.prog_done,   32'h0);
        end
        write_word(w4[2]);
        check_eq("t4_nodone", bus.prog_done, 32'h0);
        write_word(w4[3]);
        check_eq("t4_done", bus.prog_done, 32'h1);
        tick();
        for (int i = 0; i < 4; i++) begin
            fetch_chk("t4_rd", 32'h0000_07F0 + 32'(i * 4), w4[i], 2'b00);
        end
        fetch_chk("t4_w0_intact", 32'h0, w1[0], 2'b00);

        // 5: reset after two of four words
        start_load(32'h0, 10'd4);
        write_word(n5[0]);
        write_word(n5[1]);
        rst_n = 1'b0;
        bus.prog_wvalid = 1'b1;
        bus.prog_wdata  = n5[2];
        tick();
        rst_n = 1'b1;
        bus.prog_wvalid = 1'b0;
        check_eq("t5_done",   bus.prog_done,   32'h0);
        check_eq("t5_busy",   bus.busy,        32'h0);
        check_eq("t5_wready", bus.prog_wready, 32'h0);
        tick();
        check_eq("t5_done2", bus.prog_done, 32'h0);
        check_eq("t5_busy2", bus.busy,      32'h0);
        fetch_chk("t5_w0", 32'h0, n5[0], 2'b00);
        fetch_chk("t5_w1", 32'h4, n5[1], 2'b00);
        fetch_chk("t5_w2", 32'h8, w1[2], 2'b00);

        // 6: fetch and accepted start in the same cycle
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h0;
        start_load(32'h0000_0010, 10'd1);
        bus.fetch_req = 1'b0;
        check_eq("t6_valid", bus.fetch_valid, 32'h1);
        check_eq("t6_instr", bus.fetch_instr, n5[0]);
        check_eq("t6_busy",  bus.busy,        32'h1);
        check_eq("t6_wrdy",  bus.prog_wready, 32'h1);
        write_word(32'hCAFE_0013);
        check_eq("t6_done", bus.prog_done, 32'h1);
        tick();
        fetch_chk("t6_rd", 32'h0000_0010, 32'hCAFE_0013, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
